// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the sysclk divider bank.
// Default divisors target the 100 MHz board: ch0 100 kHz, ch1 1 kHz, ch2 5 kHz.
package clk_div_pkg;

    localparam int DIV_FN_W  = 32;
    localparam int DEF_N_CH  = 3;
    localparam int DEF_CNT_W = 16;

    localparam logic [DEF_N_CH*DEF_CNT_W-1:0] DIV_INIT_100MHZ =
        {16'd10000, 16'd50000, 16'd500};

    // Channel-select width; never collapses to zero bits for a single channel.
    function automatic int sel_width(input int n_ch);
        return (n_ch > 1) ? $clog2(n_ch) : 1;
    endfunction

    // A zero half-period is meaningless, so it is treated as the fastest rate.
    function automatic logic [DIV_FN_W-1:0] sanitize_div(input logic [DIV_FN_W-1:0] val);
        return (val == 32'd0) ? 32'd1 : val;
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: half-period counter, shadow/active divisor pair,
// 50% duty output clock and a registered rising-edge tick.
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             sysclk,
    input  logic             rst,
    input  logic             en,
    input  logic             sync,
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_val,
    input  logic [CNT_W-1:0] init,
    output logic             clk_out,
    output logic             tick,
    output logic             pending
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] active;
    logic [CNT_W-1:0] shadow;
    logic [CNT_W-1:0] wr_san;
    logic [CNT_W-1:0] init_san;
    logic [CNT_W-1:0] shadow_nx;
    logic             restart;
    logic             terminal;
    logic             load;

    // A write goes straight into shadow_nx so a coincident load picks it up
    // without ever raising pending; active only moves on half-period boundaries.
    always_comb begin
        wr_san    = CNT_W'(sanitize_div(DIV_FN_W'(wr_val)));
        init_san  = CNT_W'(sanitize_div(DIV_FN_W'(init)));
        shadow_nx = shadow;
        if (wr) begin
            shadow_nx = wr_san;
        end else begin
            shadow_nx = shadow;
        end
        restart  = !en || sync;
        terminal = (cnt == (active - CNT_ONE));
        load     = restart || terminal;
    end

    // Counter, divisor registers and outputs; restart dominates terminal count.
    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            cnt     <= CNT_ZERO;
            active  <= init_san;
            shadow  <= init_san;
            pending <= 1'b0;
            clk_out <= 1'b0;
            tick    <= 1'b0;
        end else begin
            shadow <= shadow_nx;
            if (load) begin
                cnt     <= CNT_ZERO;
                active  <= shadow_nx;
                pending <= 1'b0;
            end else begin
                cnt     <= cnt + CNT_ONE;
                active  <= active;
                pending <= pending | wr;
            end
            if (restart) begin
                clk_out <= 1'b0;
                tick    <= 1'b0;
            end else if (terminal) begin
                clk_out <= ~clk_out;
                tick    <= ~clk_out;
            end else begin
                clk_out <= clk_out;
                tick    <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/clk_div_bank.sv
// Bank of N_CH independent sysclk dividers with shared sync and a single
// divisor-write port addressed by div_sel.
module clk_div_bank
    import clk_div_pkg::*;
#(
    parameter int                      N_CH     = DEF_N_CH,
    parameter int                      CNT_W    = DEF_CNT_W,
    parameter logic [N_CH*CNT_W-1:0]   DIV_INIT = DIV_INIT_100MHZ,
    parameter int                      SEL_W    = sel_width(N_CH)
) (
    input  logic             sysclk,
    input  logic             rst,
    input  logic [N_CH-1:0]  en,
    input  logic             sync,
    input  logic             div_wr,
    input  logic [SEL_W-1:0] div_sel,
    input  logic [CNT_W-1:0] div_val,
    output logic [N_CH-1:0]  clk_out,
    output logic [N_CH-1:0]  tick,
    output logic [N_CH-1:0]  div_pending
);

    for (genvar ch = 0; ch < N_CH; ch++) begin : g_chan
        logic wr_ch;

        // Out-of-range selects match no channel and are dropped.
        assign wr_ch = div_wr && (div_sel == SEL_W'(ch));

        clk_div_chan #(
            .CNT_W (CNT_W)
        ) u_chan (
            .sysclk  (sysclk),
            .rst     (rst),
            .en      (en[ch]),
            .sync    (sync),
            .wr      (wr_ch),
            .wr_val  (div_val),
            .init    (DIV_INIT[ch*CNT_W +: CNT_W]),
            .clk_out (clk_out[ch]),
            .tick    (tick[ch]),
            .pending (div_pending[ch])
        );
    end

endmodule

// File: tb/tb_clk_div_bank.sv
// Self-checking bench for clk_div_bank; a reference model tracks, per channel,
// the absolute cycle of the next output toggle.
module tb_clk_div_bank;

    localparam int INIT_H [3] = '{500, 50000, 10000};

    logic        sysclk;
    logic        rst;
    logic [2:0]  en;
    logic        sync;
    logic        div_wr;
    logic [1:0]  div_sel;
    logic [15:0] div_val;
    logic [2:0]  clk_out;
    logic [2:0]  tick;
    logic [2:0]  div_pending;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [2:0] m_clk;
    logic [2:0] m_tick;
    logic [2:0] m_pend;
    int         m_shadow    [3];
    int         m_toggle_at [3];

    clk_div_bank dut (
        .sysclk      (sysclk),
        .rst         (rst),
        .en          (en),
        .sync        (sync),
        .div_wr      (div_wr),
        .div_sel     (div_sel),
        .div_val     (div_val),
        .clk_out     (clk_out),
        .tick        (tick),
        .div_pending (div_pending)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    task automatic model_reset();
        for (int ch = 0; ch < 3; ch++) begin
            m_shadow[ch]    = INIT_H[ch];
            m_toggle_at[ch] = cyc + INIT_H[ch];
        end
        m_clk  = 3'b000;
        m_tick = 3'b000;
        m_pend = 3'b000;
    endtask

    // Spec rules: a half-period lasts H cycles; restarts and half-period ends take the shadow.
    task automatic model_edge();
        for (int ch = 0; ch < 3; ch++) begin
            bit wr_here;
            int nv;
            wr_here = div_wr && (int'(div_sel) == ch);
            nv = wr_here ? ((div_val == 16'd0) ? 1 : int'(div_val)) : m_shadow[ch];
            if (rst) begin
                m_shadow[ch]    = INIT_H[ch];
                m_toggle_at[ch] = cyc + INIT_H[ch];
                m_clk[ch] = 1'b0; m_tick[ch] = 1'b0; m_pend[ch] = 1'b0;
            end else begin
                if (!en[ch] || sync) begin
                    m_clk[ch] = 1'b0; m_tick[ch] = 1'b0; m_pend[ch] = 1'b0;
                    m_toggle_at[ch] = cyc + nv;
                end else if (cyc == m_toggle_at[ch]) begin
                    m_tick[ch] = !m_clk[ch];
                    m_clk[ch]  = !m_clk[ch];
                    m_pend[ch] = 1'b0;
                    m_toggle_at[ch] = cyc + nv;
                end else begin
                    m_tick[ch] = 1'b0;
                    m_pend[ch] = m_pend[ch] | wr_here;
                end
                m_shadow[ch] = nv;
            end
        end
    endtask

    task automatic step();
        @(posedge sysclk);
        cyc++;
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        int c_en, first0, second0, first2, hi0;
        rst = 1'b1; en = 3'b000; sync = 1'b0; div_wr = 1'b0; div_sel = 2'd0; div_val = 16'd0;
        model_reset();
        repeat (3) step();
        checks++;
        if (clk_out !== 3'b000 || tick !== 3'b000 || div_pending !== 3'b000) begin
            errors++;
            $display("FAIL reset_state got clk=%b tick=%b pend=%b want 000", clk_out, tick, div_pending);
        end
        rst = 1'b0; en = 3'b111; c_en = cyc;
        first0 = -1; second0 = -1; first2 = -1; hi0 = 0;
        for (int i = 0; i < 10010; i++) begin
            step();
            checks++;
            if (clk_out !== m_clk || tick !== m_tick || div_pending !== m_pend) begin
                errors++;
                $display("FAIL model_reset_run cyc=%0d got %b/%b/%b want %b/%b/%b", cyc, clk_out, tick, div_pending, m_clk, m_tick, m_pend);
            end
            if (tick[0]) begin
                if (first0 < 0) first0 = cyc;
                else if (second0 < 0) second0 = cyc;
            end
            if (first0 >= 0 && second0 < 0 && clk_out[0]) hi0++;
            if (tick[2] && first2 < 0) first2 = cyc;
        end
        checks++;
        if (first0 != c_en + 500) begin
            errors++; $display("FAIL ch0_first_rise got %0d want %0d", first0, c_en + 500);
        end
        checks++;
        if (second0 - first0 != 1000) begin
            errors++; $display("FAIL ch0_period got %0d want 1000", second0 - first0);
        end
        checks++;
        if (hi0 != 500) begin
            errors++; $display("FAIL ch0_high_cycles got %0d want 500", hi0);
        end
        checks++;
        if (first2 != c_en + 10000) begin
            errors++; $display("FAIL ch2_first_rise got %0d want %0d", first2, c_en + 10000);
        end
    endtask

    task automatic test_shadow();
        int t_rise, fall, rise2, n;
        bit early_drop, pend_at_fall;
        t_rise = -1; n = 0;
        while (t_rise < 0 && n < 1100) begin
            step(); n++;
            if (tick[0]) t_rise = cyc;
        end
        repeat (100) step();
        div_wr = 1'b1; div_sel = 2'd0; div_val = 16'd250;
        step();
        div_wr = 1'b0;
        checks++;
        if (div_pending[0] !== 1'b1) begin
            errors++; $display("FAIL shadow_pending_set got %b want 1", div_pending[0]);
        end
        fall = -1; rise2 = -1; n = 0; early_drop = 0; pend_at_fall = 1'b1;
        while (rise2 < 0 && n < 1000) begin
            step(); n++;
            checks++;
            if (clk_out !== m_clk || tick !== m_tick || div_pending !== m_pend) begin
                errors++;
                $display("FAIL model_shadow cyc=%0d got %b/%b/%b want %b/%b/%b", cyc, clk_out, tick, div_pending, m_clk, m_tick, m_pend);
            end
            if (fall < 0 && clk_out[0] == 1'b0) begin
                fall = cyc; pend_at_fall = div_pending[0];
            end else if (fall < 0 && div_pending[0] !== 1'b1) begin
                early_drop = 1;
            end
            if (fall >= 0 && tick[0]) rise2 = cyc;
        end
        checks++;
        if (t_rise < 0 || fall != t_rise + 500) begin
            errors++; $display("FAIL shadow_old_half got %0d want %0d", fall - t_rise, 500);
        end
        checks++;
        if (rise2 - fall != 250) begin
            errors++; $display("FAIL shadow_new_half got %0d want 250", rise2 - fall);
        end
        checks++;
        if (early_drop || pend_at_fall !== 1'b0) begin
            errors++; $display("FAIL shadow_pending_window early=%0d at_fall=%b want 0/0", early_drop, pend_at_fall);
        end
    endtask

    task automatic test_min_div();
        int n, ticks;
        logic prev;
        div_wr = 1'b1; div_sel = 2'd0; div_val = 16'd0;
        step();
        div_wr = 1'b0; n = 0;
        while (div_pending[0] && n < 300) begin
            step(); n++;
            checks++;
            if (clk_out !== m_clk || tick !== m_tick || div_pending !== m_pend) begin
                errors++;
                $display("FAIL model_min_div cyc=%0d got %b/%b/%b want %b/%b/%b", cyc, clk_out, tick, div_pending, m_clk, m_tick, m_pend);
            end
        end
        checks++;
        if (div_pending[0] !== 1'b0) begin
            errors++; $display("FAIL min_div_applied got pend=%b want 0", div_pending[0]);
        end
        step();
        prev = clk_out[0]; ticks = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            checks++;
            if (clk_out[0] === prev) begin
                errors++; $display("FAIL min_div_toggle cyc=%0d got %b want %b", cyc, clk_out[0], ~prev);
            end
            if (tick[0]) ticks++;
            prev = clk_out[0];
        end
        checks++;
        if (ticks != 10) begin
            errors++; $display("FAIL min_div_ticks got %0d want 10", ticks);
        end
        div_wr = 1'b1; div_sel = 2'd3; div_val = 16'd9;
        step();
        div_wr = 1'b0;
        checks++;
        if (div_pending !== 3'b000) begin
            errors++; $display("FAIL bad_sel_ignored got pend=%b want 000", div_pending);
        end
        for (int i = 0; i < 20; i++) begin
            step();
            checks++;
            if (clk_out !== m_clk || tick !== m_tick || div_pending !== m_pend) begin
                errors++;
                $display("FAIL model_bad_sel cyc=%0d got %b/%b/%b want %b/%b/%b", cyc, clk_out, tick, div_pending, m_clk, m_tick, m_pend);
            end
        end
    endtask

    task automatic test_terminal_write();
        int n, tw, tnext;
        bit pend_seen;
        logic prev;
        en[1] = 1'b0; div_wr = 1'b1; div_sel = 2'd1; div_val = 16'd20;
        step();
        div_wr = 1'b0; en[1] = 1'b1; n = 0;
        while (cyc + 1 != m_toggle_at[1] && n < 40) begin
            step(); n++;
        end
        div_wr = 1'b1; div_sel = 2'd1; div_val = 16'd7;
        step();
        div_wr = 1'b0; tw = cyc; prev = clk_out[1];
        pend_seen = div_pending[1]; tnext = -1;
        for (int i = 0; i < 12; i++) begin
            step();
            checks++;
            if (clk_out !== m_clk || tick !== m_tick || div_pending !== m_pend) begin
                errors++;
                $display("FAIL model_term_wr cyc=%0d got %b/%b/%b want %b/%b/%b", cyc, clk_out, tick, div_pending, m_clk, m_tick, m_pend);
            end
            if (div_pending[1]) pend_seen = 1;
            if (tnext < 0 && clk_out[1] !== prev) tnext = cyc;
        end
        checks++;
        if (pend_seen) begin
            errors++; $display("FAIL term_wr_pending got 1 want 0");
        end
        checks++;
        if (tnext - tw != 7) begin
            errors++; $display("FAIL term_wr_half got %0d want 7", tnext - tw);
        end
    endtask

    task automatic test_sync();
        int cs, first;
        for (int ch = 0; ch < 3; ch++) begin
            div_wr = 1'b1; div_sel = 2'(ch); div_val = 16'($urandom_range(2, 9));
            step();
            div_wr = 1'b0;
            repeat ($urandom_range(5, 30)) step();
        end
        for (int ch = 0; ch < 3; ch++) begin
            div_wr = 1'b1; div_sel = 2'(ch); div_val = 16'd4;
            step();
        end
        div_wr = 1'b0;
        repeat ($urandom_range(0, 7)) step();
        sync = 1'b1;
        step();
        sync = 1'b0; cs = cyc; first = -1;
        checks++;
        if (clk_out !== 3'b000 || tick !== 3'b000 || div_pending !== 3'b000) begin
            errors++; $display("FAIL sync_clear got %b/%b/%b want 000", clk_out, tick, div_pending);
        end
        for (int i = 0; i < 40; i++) begin
            step();
            checks++;
            if (clk_out !== m_clk || tick !== m_tick || div_pending !== m_pend
                || !(clk_out == 3'b000 || clk_out == 3'b111) || !(tick == 3'b000 || tick == 3'b111)) begin
                errors++;
                $display("FAIL sync_aligned cyc=%0d got %b/%b/%b want %b/%b/%b", cyc, clk_out, tick, div_pending, m_clk, m_tick, m_pend);
            end
            if (first < 0 && tick[0]) first = cyc;
        end
        checks++;
        if (first != cs + 4) begin
            errors++; $display("FAIL sync_first_rise got %0d want %0d", first - cs, 4);
        end
        en = 3'b011;
        repeat ($urandom_range(1, 6)) step();
        sync = 1'b1;
        step();
        sync = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            checks++;
            if (clk_out[2] !== 1'b0 || clk_out !== m_clk || tick !== m_tick || div_pending !== m_pend) begin
                errors++;
                $display("FAIL sync_disabled_ch2 cyc=%0d got %b/%b/%b want %b/%b/%b", cyc, clk_out, tick, div_pending, m_clk, m_tick, m_pend);
            end
        end
    endtask

    task automatic test_disable_reset();
        int n, tr, first, c;
        en = 3'b111; n = 0;
        step();
        while (!(clk_out[0] && !tick[0]) && n < 20) begin
            step(); n++;
        end
        en[0] = 1'b0;
        step();
        checks++;
        if (clk_out[0] !== 1'b0 || tick[0] !== 1'b0) begin
            errors++; $display("FAIL disable_low got clk=%b tick=%b want 0/0", clk_out[0], tick[0]);
        end
        en[0] = 1'b1; tr = cyc; first = -1; n = 0;
        while (first < 0 && n < 12) begin
            step(); n++;
            checks++;
            if (clk_out !== m_clk || tick !== m_tick || div_pending !== m_pend) begin
                errors++;
                $display("FAIL model_reenable cyc=%0d got %b/%b/%b want %b/%b/%b", cyc, clk_out, tick, div_pending, m_clk, m_tick, m_pend);
            end
            if (tick[0]) first = cyc;
        end
        checks++;
        if (first != tr + 4) begin
            errors++; $display("FAIL reenable_first_rise got %0d want 4", first - tr);
        end
        div_wr = 1'b1; div_sel = 2'd2; div_val = 16'd33;
        step();
        div_wr = 1'b0;
        step();
        rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if (clk_out !== 3'b000 || tick !== 3'b000 || div_pending !== 3'b000) begin
            errors++; $display("FAIL async_reset got %b/%b/%b want 000", clk_out, tick, div_pending);
        end
        repeat (2) step();
        rst = 1'b0; c = cyc; first = -1; n = 0;
        while (first < 0 && n < 600) begin
            step(); n++;
            checks++;
            if (clk_out !== m_clk || tick !== m_tick || div_pending !== m_pend) begin
                errors++;
                $display("FAIL model_after_reset cyc=%0d got %b/%b/%b want %b/%b/%b", cyc, clk_out, tick, div_pending, m_clk, m_tick, m_pend);
            end
            if (tick[0]) first = cyc;
        end
        checks++;
        if (first != c + 500) begin
            errors++; $display("FAIL reset_div_restored got %0d want 500", first - c);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            for (int ch = 0; ch < 3; ch++) en[ch] = ($urandom_range(0, 19) != 0);
            sync    = ($urandom_range(0, 39) == 0);
            div_wr  = ($urandom_range(0, 7) == 0);
            div_sel = 2'($urandom_range(0, 3));
            div_val = 16'($urandom_range(0, 12));
            step();
            checks++;
            if (clk_out !== m_clk || tick !== m_tick || div_pending !== m_pend) begin
                errors++;
                $display("FAIL model_random cyc=%0d got %b/%b/%b want %b/%b/%b", cyc, clk_out, tick, div_pending, m_clk, m_tick, m_pend);
            end
        end
        sync = 1'b0; div_wr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_shadow();
        test_min_div();
        test_terminal_write();
        test_sync();
        test_disable_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
